// File: rtl/mem_access_stage_pkg.sv
// Shared types and constants for the memory-access stage: bus widths, memory op codes,
// FSM states and the registered-state record.
package mem_access_stage_pkg;

  localparam int REG_BUS      = 32;
  localparam int REG_ADDR_BUS = 5;
  localparam int MEM_BYTE_BUS = 8;

  localparam logic                    DISABLE      = 1'b0;
  localparam logic [REG_BUS-1:0]      ZERO_WORD    = '0;
  localparam logic [REG_ADDR_BUS-1:0] NOP_REG_ADDR = '0;

  typedef enum logic [3:0] {
    MEM_NOP = 4'h0,
    MEM_LB  = 4'h1,
    MEM_LH  = 4'h2,
    MEM_LW  = 4'h3,
    MEM_LBU = 4'h4,
    MEM_LHU = 4'h5,
    MEM_SB  = 4'h6,
    MEM_SH  = 4'h7,
    MEM_SW  = 4'h8
  } mem_op_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // Every register of the stage in one record, so checkers can bind to a single signal.
  typedef struct packed {
    state_t                    state;
    logic [1:0]                cnt;
    mem_op_t                   op;
    logic [REG_BUS-1:0]        addr;
    logic [REG_BUS-1:0]        sdata;
    logic [REG_ADDR_BUS-1:0]   rd;
    logic                      en;
    logic [REG_BUS-1:0]        rd_buf;
  } stage_regs_t;

  function automatic logic is_mem_op(input logic [3:0] op);
    return (op >= 4'h1) && (op <= 4'h8);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op >= 4'h6) && (op <= 4'h8);
  endfunction

  // Index of the final byte of the access (access length minus one).
  function automatic logic [1:0] last_idx(input logic [3:0] op);
    case (op)
      MEM_LB, MEM_LBU, MEM_SB: return 2'd0;
      MEM_LH, MEM_LHU, MEM_SH: return 2'd1;
      default:                 return 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_stage_load_ext.sv
// Load-result extension: turns the assembled read buffer into the 32-bit
// write-back value according to the load width and signedness.
module mem_load_ext
  import mem_access_stage_pkg::*;
(
  input  mem_op_t              op,
  input  logic [REG_BUS-1:0]   raw,
  output logic [REG_BUS-1:0]   data
);

  always_comb begin
    data = raw;
    case (op)
      MEM_LB:  data = {{24{raw[7]}}, raw[7:0]};
      MEM_LH:  data = {{16{raw[15]}}, raw[15:0]};
      MEM_LBU: data = {24'd0, raw[7:0]};
      MEM_LHU: data = {16'd0, raw[15:0]};
      default: data = raw;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access stage: runs loads/stores one byte at a time over the memory-controller
// port while stalling the pipeline, then presents the write-back triple for one cycle.
module mem_access_stage
  import mem_access_stage_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ex_w_enable,
  input  logic [REG_ADDR_BUS-1:0]   ex_w_addr,
  input  logic [REG_BUS-1:0]        ex_w_data,
  input  logic [3:0]                ex_mem_op,
  input  logic [REG_BUS-1:0]        ex_mem_addr,
  input  logic [REG_BUS-1:0]        ex_store_data,
  input  logic [5:0]                stall,
  input  logic                      mc_ack,
  input  logic [MEM_BYTE_BUS-1:0]   mc_rdata,
  output logic                      mc_req,
  output logic                      mc_we,
  output logic [REG_BUS-1:0]        mc_addr,
  output logic [MEM_BYTE_BUS-1:0]   mc_wdata,
  output logic                      stall_req,
  output logic                      me_w_enable,
  output logic [REG_ADDR_BUS-1:0]   me_w_addr,
  output logic [REG_BUS-1:0]        me_w_data
);

  stage_regs_t        q, d;
  logic [REG_BUS-1:0] load_data;
  logic               unused_stall;

  assign unused_stall = ^{stall[5], stall[3:0]};

  mem_load_ext u_load_ext (
    .op   (q.op),
    .raw  (q.rd_buf),
    .data (load_data)
  );

  always_ff @(posedge clk) begin
    if (rst) q <= '0;
    else     q <= d;
  end

  // Handshake: mc_req holds mc_we/mc_addr/mc_wdata stable until a cycle with mc_ack
  // high; that edge transfers the byte (mc_rdata is valid in that same cycle).
  always_comb begin
    d           = q;
    mc_req      = 1'b0;
    mc_we       = 1'b0;
    mc_addr     = ZERO_WORD;
    mc_wdata    = '0;
    stall_req   = 1'b0;
    me_w_enable = DISABLE;
    me_w_addr   = NOP_REG_ADDR;
    me_w_data   = ZERO_WORD;

    case (q.state)
      ST_IDLE: begin
        if (is_mem_op(ex_mem_op)) begin
          stall_req = 1'b1;
          d.state   = ST_ACCESS;
          d.cnt     = 2'd0;
          d.rd_buf  = ZERO_WORD;
          d.op      = mem_op_t'(ex_mem_op);
          d.addr    = ex_mem_addr;
          d.sdata   = ex_store_data;
          d.rd      = ex_w_addr;
          d.en      = ex_w_enable;
        end else begin
          me_w_enable = ex_w_enable;
          me_w_addr   = ex_w_addr;
          me_w_data   = ex_w_data;
        end
      end

      ST_ACCESS: begin
        stall_req = 1'b1;
        mc_req    = 1'b1;
        mc_we     = is_store(q.op);
        mc_addr   = q.addr + {30'd0, q.cnt};
        mc_wdata  = q.sdata[{q.cnt, 3'b000} +: 8];
        if (mc_ack) begin
          if (!is_store(q.op)) d.rd_buf[{q.cnt, 3'b000} +: 8] = mc_rdata;
          if (q.cnt == last_idx(q.op)) d.state = ST_DONE;
          else                         d.cnt   = q.cnt + 2'd1;
        end
      end

      ST_DONE: begin
        if (!is_store(q.op)) begin
          me_w_enable = q.en;
          me_w_addr   = q.rd;
          me_w_data   = load_data;
        end
        if (!stall[4]) d.state = ST_IDLE;
      end

      default: d.state = ST_IDLE;
    endcase

    // Reset wins over everything, including a pass-through in IDLE.
    if (rst) begin
      mc_req      = 1'b0;
      mc_we       = 1'b0;
      mc_addr     = ZERO_WORD;
      mc_wdata    = '0;
      stall_req   = 1'b0;
      me_w_enable = DISABLE;
      me_w_addr   = NOP_REG_ADDR;
      me_w_data   = ZERO_WORD;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: vector table, hand-written corner sequences and random ops
// checked against a byte-addressed memory model and access-length arithmetic.
module tb_mem_access_stage;
  import mem_access_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_w_enable;
  logic [4:0]  ex_w_addr;
  logic [31:0] ex_w_data;
  logic [3:0]  ex_mem_op;
  logic [31:0] ex_mem_addr;
  logic [31:0] ex_store_data;
  logic [5:0]  stall;
  logic        mc_ack;
  logic [7:0]  mc_rdata;
  logic        mc_req;
  logic        mc_we;
  logic [31:0] mc_addr;
  logic [7:0]  mc_wdata;
  logic        stall_req;
  logic        me_w_enable;
  logic [4:0]  me_w_addr;
  logic [31:0] me_w_data;
  logic        ext_stall4 = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [40:0] exp_q[$];
  logic [7:0]  mem [logic [31:0]];

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [4:0]  rd;
    logic        en;
    logic        preload;
    logic [31:0] init_word;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[10];

  // ---------------- clock / reset / stall controller ----------------
  always #5 clk = ~clk;
  assign stall = stall_req ? 6'b011111 : {1'b0, ext_stall4, 4'b0000};

  mem_access_stage dut (
    .clk           (clk),
    .rst           (rst),
    .ex_w_enable   (ex_w_enable),
    .ex_w_addr     (ex_w_addr),
    .ex_w_data     (ex_w_data),
    .ex_mem_op     (ex_mem_op),
    .ex_mem_addr   (ex_mem_addr),
    .ex_store_data (ex_store_data),
    .stall         (stall),
    .mc_ack        (mc_ack),
    .mc_rdata      (mc_rdata),
    .mc_req        (mc_req),
    .mc_we         (mc_we),
    .mc_addr       (mc_addr),
    .mc_wdata      (mc_wdata),
    .stall_req     (stall_req),
    .me_w_enable   (me_w_enable),
    .me_w_addr     (me_w_addr),
    .me_w_data     (me_w_data)
  );

  // ---------------- reference model ----------------
  function automatic int op_len(input logic [3:0] op);
    case (op)
      4'h1, 4'h4, 4'h6: return 1;
      4'h2, 4'h5, 4'h7: return 2;
      4'h3, 4'h8:       return 4;
      default:          return 0;
    endcase
  endfunction

  function automatic logic [7:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a[7:0] ^ 8'h5A;
  endfunction

  function automatic logic [31:0] model_load(input logic [3:0] op, input logic [31:0] a);
    longint unsigned v = 0;
    int n = op_len(op);
    for (int i = 0; i < n; i++) v = v | (longint'(mem_rd(a + 32'(i))) << (8 * i));
    if ((op == 4'h1 || op == 4'h2) && v[8*n-1]) v = v - (64'd1 << (8 * n));
    return v[31:0];
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks (entered and left at posedge+1) ----------------
  task automatic set_nop();
    ex_w_enable = 1'b0; ex_w_addr = '0; ex_w_data = '0;
    ex_mem_op = 4'h0; ex_mem_addr = '0; ex_store_data = '0;
  endtask

  task automatic pass_check(input logic [3:0] op, input logic en, input logic [4:0] rd,
                            input logic [31:0] data);
    ex_mem_op = op; ex_w_enable = en; ex_w_addr = rd; ex_w_data = data;
    ex_mem_addr = $urandom; ex_store_data = $urandom;
    mc_ack = 1'($urandom_range(0, 1));
    #1;
    chk("pass_en", 32'(me_w_enable), 32'(en));
    chk("pass_addr", 32'(me_w_addr), 32'(rd));
    chk("pass_data", me_w_data, data);
    chk("pass_stall_req", 32'(stall_req), 0);
    chk("pass_mc_req", 32'(mc_req), 0);
    @(posedge clk); #1;
  endtask

  task automatic run_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                        input logic [4:0] rd, input logic en, input logic [31:0] exp_data,
                        input int ack_pct, input int first_wait, input int hold);
    int len = op_len(op);
    logic st = (op >= 4'h6);
    int c = 0, waits = 0, stalls = 0;
    int wait_left = first_wait, hold_left = hold;
    logic fin = 1'b0;
    logic [40:0] e;
    exp_q.delete();
    for (int i = 0; i < len; i++)
      exp_q.push_back({st, addr + 32'(i), st ? sdata[8*i +: 8] : 8'h00});
    ex_mem_op = op; ex_mem_addr = addr; ex_store_data = sdata;
    ex_w_addr = rd; ex_w_enable = en; ex_w_data = $urandom;
    while (!fin && c < 64) begin
      #1;
      if (mc_req) begin
        if (wait_left > 0) begin mc_ack = 1'b0; wait_left--; end
        else mc_ack = ($urandom_range(0, 99) < ack_pct);
      end else begin
        mc_ack = 1'($urandom_range(0, 1));
      end
      ext_stall4 = (c > 0) && !stall_req && (hold_left > 0);
      #1 mc_rdata = mem_rd(mc_addr);
      #3;
      if (stall_req) stalls++;
      if (c == 0) begin
        chk("idle_stall_req", 32'(stall_req), 1);
        chk("idle_mc_req", 32'(mc_req), 0);
        chk("idle_w_en", 32'(me_w_enable), 0);
        chk("idle_w_addr", 32'(me_w_addr), 0);
        chk("idle_w_data", me_w_data, 0);
      end else if (!stall_req) begin
        chk("done_mc_req", 32'(mc_req), 0);
        chk("done_w_en", 32'(me_w_enable), st ? 0 : 32'(en));
        chk("done_w_addr", 32'(me_w_addr), st ? 0 : 32'(rd));
        chk("done_w_data", me_w_data, st ? 32'd0 : exp_data);
        if (hold_left > 0) hold_left--;
        else fin = 1'b1;
      end else begin
        chk("access_mc_req", 32'(mc_req), 1);
        if (!mc_ack) waits++;
        else if (exp_q.size() == 0) chk("extra_transfer", mc_addr, 32'hFFFF_FFFF ^ mc_addr);
        else begin
          e = exp_q.pop_front();
          chk("xfer_we", 32'(mc_we), 32'(e[40]));
          chk("xfer_addr", mc_addr, e[39:8]);
          if (e[40]) chk("xfer_wdata", 32'(mc_wdata), 32'(e[7:0]));
          if (mc_we) mem[mc_addr] = mc_wdata;
        end
      end
      c++;
      @(posedge clk); #1;
    end
    ext_stall4 = 1'b0;
    chk("op_finished", 32'(fin), 1);
    chk("transfers_left", 32'(exp_q.size()), 0);
    chk("stall_cycles", 32'(stalls), 32'(len + 1 + waits));
    chk("total_cycles", 32'(c), 32'(len + 2 + waits + hold));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [3:0]  r_op;
    logic [31:0] r_addr;

    vecs[0] = '{4'h0, 32'h0,        32'h0,        5'd5,  1'b1, 1'b0, 32'h0,        32'h12345678};
    vecs[1] = '{4'h3, 32'h100,      32'h0,        5'd7,  1'b1, 1'b1, 32'h12345678, 32'h12345678};
    vecs[2] = '{4'h1, 32'h201,      32'h0,        5'd8,  1'b1, 1'b1, 32'h00000080, 32'hFFFFFF80};
    vecs[3] = '{4'h4, 32'h205,      32'h0,        5'd8,  1'b1, 1'b1, 32'h00000080, 32'h00000080};
    vecs[4] = '{4'h2, 32'h302,      32'h0,        5'd10, 1'b1, 1'b1, 32'h0000BEEF, 32'hFFFFBEEF};
    vecs[5] = '{4'h5, 32'h307,      32'h0,        5'd11, 1'b0, 1'b1, 32'h0000BEEF, 32'h0000BEEF};
    vecs[6] = '{4'h8, 32'h401,      32'hCAFEF00D, 5'd9,  1'b1, 1'b0, 32'h0,        32'h0};
    vecs[7] = '{4'h3, 32'h401,      32'h0,        5'd12, 1'b1, 1'b0, 32'h0,        32'hCAFEF00D};
    vecs[8] = '{4'hB, 32'h0,        32'h0,        5'd31, 1'b1, 1'b0, 32'h0,        32'hDEADBEEF};
    vecs[9] = '{4'h6, 32'h500,      32'h11223344, 5'd1,  1'b1, 1'b0, 32'h0,        32'h0};

    // Reset with a live ALU op on the inputs: outputs must still read zero.
    rst = 1'b1; mc_ack = 1'b0; mc_rdata = '0;
    ex_w_enable = 1'b1; ex_w_addr = 5'd5; ex_w_data = 32'h12345678;
    ex_mem_op = 4'h0; ex_mem_addr = '0; ex_store_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_w_en", 32'(me_w_enable), 0);
    chk("rst_w_addr", 32'(me_w_addr), 0);
    chk("rst_w_data", me_w_data, 0);
    chk("rst_stall_req", 32'(stall_req), 0);
    chk("rst_mc_req", 32'(mc_req), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    set_nop();

    for (int v = 0; v < 10; v++) begin
      if (op_len(vecs[v].op) == 0) begin
        pass_check(vecs[v].op, vecs[v].en, vecs[v].rd, vecs[v].exp_data);
      end else begin
        if (vecs[v].preload)
          for (int i = 0; i < op_len(vecs[v].op); i++)
            mem[vecs[v].addr + 32'(i)] = vecs[v].init_word[8*i +: 8];
        run_op(vecs[v].op, vecs[v].addr, vecs[v].sdata, vecs[v].rd, vecs[v].en,
               vecs[v].exp_data, 100, 0, 0);
      end
    end
    chk("sb_mem", 32'(mem_rd(32'h500)), 32'h44);
    chk("sb_neighbour", 32'(mem_rd(32'h501)), 32'(8'h01 ^ 8'h5A));

    // Halfword store across the top of the address space with two wait cycles on byte 0.
    run_op(4'h7, 32'hFFFF_FFFF, 32'hAABBCCDD, 5'd3, 1'b1, 32'h0, 100, 2, 0);
    chk("sh_wrap_b0", 32'(mem_rd(32'hFFFF_FFFF)), 32'hDD);
    chk("sh_wrap_b1", 32'(mem_rd(32'h0000_0000)), 32'hCC);

    // Result held through two externally stalled DONE cycles.
    run_op(4'h3, 32'h100, 32'h0, 5'd7, 1'b1, 32'h12345678, 100, 0, 2);

    // Reset during the third byte of a word load.
    mem[32'h600] = 8'h11; mem[32'h601] = 8'h22; mem[32'h602] = 8'h33; mem[32'h603] = 8'h44;
    ex_mem_op = 4'h3; ex_mem_addr = 32'h600; ex_w_addr = 5'd3; ex_w_enable = 1'b1;
    mc_ack = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1 mc_rdata = mem_rd(mc_addr);
      if (k == 3) rst = 1'b1;
      #3;
      if (k == 2) chk("pre_rst_addr", mc_addr, 32'h601);
      if (k == 3) begin
        chk("mid_rst_mc_req", 32'(mc_req), 0);
        chk("mid_rst_stall_req", 32'(stall_req), 0);
        chk("mid_rst_w_en", 32'(me_w_enable), 0);
        chk("mid_rst_w_addr", 32'(me_w_addr), 0);
        chk("mid_rst_w_data", me_w_data, 0);
      end
      @(posedge clk); #1;
    end
    rst = 1'b0;
    set_nop();
    #1;
    chk("post_rst_stall_req", 32'(stall_req), 0);
    chk("post_rst_mc_req", 32'(mc_req), 0);
    chk("post_rst_w_en", 32'(me_w_enable), 0);
    @(posedge clk); #1;
    pass_check(4'h0, 1'b1, 5'd5, 32'h12345678);
    run_op(4'h3, 32'h600, 32'h0, 5'd3, 1'b1, 32'h44332211, 100, 0, 0);

    // Random ops over a small window so stores and loads overlap.
    for (int r = 0; r < 40; r++) begin
      r_op = 4'($urandom_range(0, 10));
      if (r_op > 4'h8) r_op = 4'hF;
      r_addr = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFE : 32'h40 + 32'($urandom_range(0, 12));
      if (op_len(r_op) == 0)
        pass_check(r_op, 1'($urandom_range(0, 1)), 5'($urandom), $urandom);
      else
        run_op(r_op, r_addr, $urandom, 5'($urandom), 1'($urandom_range(0, 1)),
               model_load(r_op, r_addr), 60, $urandom_range(0, 1), $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access stage of the five-stage RISC-V core, feeding the MEM/WB pipeline register. It takes the EX/MEM operation (ALU result or load/store) and performs loads and stores through the byte-wide memory-controller port, one byte per handshake. While an access is in flight it raises a stall request. It then presents the write-back triple `me_w_enable`/`me_w_addr`/`me_w_data` for exactly one un-stalled cycle.

## Interface
Parameters: none. Bus widths come from `Defines.v` (`RegBus`=32, `RegAddrBus`=5).

Clocking and reset: one clock `clk`; reset `rst` is synchronous, active-high.

- `clk` in 1: core clock.
- `rst` in 1: synchronous, active-high reset.
- `ex_w_enable` in 1: instruction writes rd.
- `ex_w_addr` in 5: rd.
- `ex_w_data` in 32: ALU result; used when there is no memory op.
- `ex_mem_op` in 4: `MEM_NOP`, `MEM_LB`, `MEM_LH`, `MEM_LW`, `MEM_LBU`, `MEM_LHU`, `MEM_SB`, `MEM_SH`, `MEM_SW`. Any other code is treated as `MEM_NOP`.
- `ex_mem_addr` in 32: effective byte address.
- `ex_store_data` in 32: rs2 value for stores.
- `stall` in 6: global stall vector; this block reads only `stall[4]`.
- `mc_ack` in 1: memory controller accepts the current byte.
- `mc_rdata` in 8: read byte, valid in the cycle `mc_ack` is high.
- `mc_req` out 1: byte request.
- `mc_we` out 1: 1 = write, 0 = read.
- `mc_addr` out 32: byte address.
- `mc_wdata` out 8: write byte.
- `stall_req` out 1: to the stall controller. The controller drives `stall=6'b011111` while this is high.
- `me_w_enable` out 1: to MEM/WB.
- `me_w_addr` out 5: to MEM/WB.
- `me_w_data` out 32: to MEM/WB.

## Operation
- FSM states: IDLE, ACCESS, DONE. Registered state: the state, byte counter `cnt[1:0]`, latched op/addr/store-data/rd/enable, and 32-bit read buffer `buf`.
- Access length `len`: 1 for B/BU, 2 for H/HU, 4 for W.
- **IDLE**, op is NOP:
  - Combinational pass-through: `me_w_*` = `ex_w_*`.
  - `stall_req`=0, `mc_req`=0.
- **IDLE**, op is a memory op:
  - `stall_req`=1.
  - `me_w_enable`=`Disable`, `me_w_addr`=`NOPRegAddr`, `me_w_data`=`ZeroWord`.
  - Latch all `ex_*` inputs and clear `cnt` and `buf`, then go to ACCESS.
- **ACCESS**:
  - `stall_req`=1 and `mc_req`=1.
  - `mc_we` is 1 for stores.
  - `mc_addr` = latched addr + `cnt`, modulo 2^32.
  - `mc_wdata` = store byte `cnt` (little-endian).
  - On `mc_ack`: a load writes `mc_rdata` into `buf[8*cnt+:8]`. If `cnt==len-1`, go to DONE; otherwise `cnt++`.
  - Without `mc_ack`, all outputs hold stable.
- **DONE**:
  - `stall_req`=0, `mc_req`=0.
  - Loads: `me_w_enable`=latched enable, `me_w_addr`=latched rd, `me_w_data`=extended `buf`.
  - Extension: LB sign-extends bit 7, LH sign-extends bit 15, LBU/LHU zero-extend, LW passes `buf` through.
  - Stores: Disable / `NOPRegAddr` / `ZeroWord`.
  - Go to IDLE when `stall[4]`=0; otherwise hold DONE.
- Alignment is not required. Misaligned H/W accesses are legal because each byte is accessed separately.
- `rst` high, in any state and even mid-access:
  - Next state is IDLE; `cnt`, `buf` and latches are cleared.
  - While `rst` is high, `mc_req`, `stall_req` and `me_w_enable` are forced to 0, `me_w_addr`=0, `me_w_data`=0.
  - An interrupted store may leave memory partially written; this is acceptable.

## Timing
- Reset values of all outputs: 0.
- NOP / ALU op: zero-cycle latency; no stall.
- Memory op with `mc_ack` held high: 1 (IDLE) + `len` (ACCESS) + 1 (DONE) cycles.
  - LW = 6 cycles.
  - LB = 3 cycles.
  - `stall_req` is high for `len`+1 cycles.
- Each `mc_ack` wait cycle adds one cycle.
- At most one byte is transferred per cycle. `mc_req` never rises in the same cycle `stall_req` first rises.
- MEM/WB captures the result on the DONE-cycle edge. The next EX/MEM instruction is seen in IDLE the cycle after.
- Back-to-back memory ops: the second op's IDLE cycle directly follows the first op's DONE cycle.

## Structure
- Add to `Defines.v`:
  - `MEM_*` op codes (4'h0–4'h8).
  - `MemByteBus` [7:0].
  - Existing `Enable`, `Disable`, `ZeroWord`, `NOPRegAddr`, `RegBus`, `RegAddrBus` are reused.
- One sub-module, `mem_load_ext`: combinational op + 32-bit buffer → extended 32-bit load value.

## Test plan
- ALU op, `ex_w_enable`=1, rd=5, data=0x12345678 → same cycle `me_w_*`=(1, 5, 0x12345678); `stall_req`=0, `mc_req`=0.
- LW addr 0x100, `mc_ack` always 1, bytes 0x78, 0x56, 0x34, 0x12 → four reads at 0x100–0x103; in DONE `me_w_data`=0x12345678; `stall_req` high for 5 cycles.
- LB / LBU of byte 0x80 → 0xFFFFFF80 / 0x00000080. LH / LHU of 0xBEEF → 0xFFFFBEEF / 0x0000BEEF.
- SH data 0xAABBCCDD, addr 0xFFFFFFFF, `mc_ack` low for 2 cycles on byte 0 → writes 0xDD @0xFFFFFFFF, then 0xCC @0x00000000; in DONE `me_w_enable`=0; total 6 cycles.
- `rst` asserted during the 3rd byte of an LW → next cycle IDLE with all outputs 0. A following ALU op passes through unaffected.
- `stall[4]`=1 externally during DONE for 2 cycles → load result held stable for those cycles; IDLE only after `stall[4]` drops.
